ram_port_arbiter: RTL and testbench
===================================

# ram_port_arbiter

Shares one single-port, 32-bit-wide, synchronous-read RAM between the SERV register-file byte port and the Wishbone data port. RF reads get absolute priority. RF writes are posted into a 2-entry write FIFO with read forwarding. Wishbone accesses are granted only in idle, coherent cycles. The block sits between the RF/Wishbone sources and the shared RAM macro, in place of the separate RF RAM and memory interface.

## Interface
- memsize, 1024: RAM size in bytes; the RAM holds memsize/4 words.
- rf_base, 768: byte offset of the RF region; must be word-aligned.
- aw, $clog2(memsize/4): RAM word-address width (derived).

- clk_top  in  1  single clock.
- rst_n_top  in  1  reset, asynchronous, active-low.
- i_raddr_top  in  8  RF read byte address.
- i_ren_top  in  1  RF read strobe.
- i_waddr_top  in  8  RF write byte address.
- i_wdata_top  in  8  RF write data.
- i_wen_top  in  1  RF write strobe.
- o_rdata_top  out  8  RF read data.
- i_wb_adr_top  in  [9:2]  Wishbone word address.
- i_wb_dat_top  in  32  Wishbone write data.
- i_wb_sel_top  in  4  Wishbone byte selects.
- i_wb_stb_top  in  1  Wishbone strobe (classic cycle).
- i_wb_we_top  in  1  Wishbone write enable.
- o_wb_ack_top  out  1  Wishbone acknowledge.
- o_wb_rdt_top  out  32  Wishbone read data.
- o_mem_addr  out  aw  RAM word address.
- o_mem_we  out  1  RAM write enable.
- o_mem_be  out  4  RAM byte enables.
- o_mem_wdata  out  32  RAM write data.
- i_mem_rdata  in  32  RAM read data, valid 1 cycle after the access.
- o_ovf_top  out  1  sticky FIFO-overflow flag.

## Operation
- **RF address map:** byte address b = rf_base + addr. RAM word = b[9:2] modulo memsize/4; lane = b[1:0].
- **One RAM operation per cycle.** Priority is RF read > FIFO drain > Wishbone.
- **RF read:** issued in the same cycle as i_ren_top.
  - If any FIFO entry matches the address, the newest match wins and its data is forwarded.
  - A write enqueued in the same cycle is not forwarded; the read returns the older value.
- **RF write:** always enqueued, never written directly to RAM.
  - Drain happens when there is no RF read and the FIFO is non-empty: pop the head and write 1 byte (be = one-hot lane, data replicated on all lanes).
  - Enqueue and pop in the same cycle are both performed.
  - Full FIFO, write, and no pop: the write is dropped and o_ovf_top is set until reset.
  - Integration guarantees at most one RF read per two cycles.
- **Wishbone FSM states:** IDLE and ACK.
  - IDLE→ACK when stb is high, there is no RF read, the FIFO is empty, and the FIFO is not receiving an RF write in that cycle. The access is performed in that cycle: be = sel, and be = 0 on reads.
  - ACK: o_wb_ack_top = 1 for exactly one cycle, then return to IDLE.
  - stb is ignored during the ACK cycle, so there is no double access.
- **Wrap-around:** FIFO pointers are 1 bit each, plus a count of 0..2.

## Timing
- **RF read latency:** i_ren_top at cycle N → o_rdata_top valid at N+1 only; it is 0 in every other cycle.
- **Wishbone:** grant at cycle N → ack at N+1.
  - o_wb_rdt_top = i_mem_rdata at N+1; it is 0 whenever ack is low.
  - Minimum 2 cycles per transaction; wait is unbounded while RF/FIFO traffic continues.
- **RF write visibility in RAM:** ≥1 cycle after enqueue. It is visible to RF reads immediately via forwarding.
- **Reset values:** o_rdata_top 0, o_wb_ack_top 0, o_wb_rdt_top 0, o_ovf_top 0, o_mem_we 0, o_mem_be 0, o_mem_addr 0, o_mem_wdata 0, FIFO empty, FSM IDLE.
- **Reset mid-operation:** pending FIFO writes are lost and an in-flight ack is cancelled. RAM contents are not reset.

## Structure
- **Package ram_arb_pkg:** FSM state enum (IDLE, ACK), FIFO entry struct (addr 8, data 8), constant FIFO_DEPTH = 2.
- **Sub-module rf_wr_fifo:** 2-entry FIFO with push/pop/count and a combinational newest-match forward lookup.
- Everything else stays in ram_port_arbiter.

## Test plan
- **RF write then read:** write 0x0A←0x5A, read 0x0A the next cycle → forwarded 0x5A at N+1. Idle 3 cycles, read again → 0x5A from RAM; RAM word 194 lane 2 holds 0x5A.
- **Wishbone round trip:** Wishbone write adr 0x10, data 0xDEADBEEF, sel 0xF; then read adr 0x10 → ack 1 cycle after grant, rdt 0xDEADBEEF. A read with sel 0x3 after a write of 0x0000CAFE with sel 0x3 → low half 0xCAFE.
- **Wishbone held off:** hold stb while RF reads every other cycle and 2 writes are queued → no grant until the FIFO is empty and a no-read cycle occurs; exactly one ack.
- **FIFO overflow:** 3 RF writes on consecutive cycles with a continuous RF read → 3rd write dropped, o_ovf_top = 1 and sticky; the first two are drained in order afterward.
- **Forwarding priority:** writes 0x05←0x11 then 0x05←0x22 are queued; read 0x05 → 0x22.
- **Reset mid-transaction:** assert rst_n_top low during the ACK state and with 2 FIFO entries → ack and all outputs drop to 0 asynchronously; after release, RAM is unchanged by the pending writes.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// Shared types for the RF / Wishbone RAM port arbiter: Wishbone FSM states,
// posted RF-write FIFO entries and the byte-lane decode helper.
package ram_arb_pkg;

    localparam int FIFO_DEPTH = 2;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } wb_state_e;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } rf_wr_entry_t;

    function automatic logic [3:0] lane_onehot(input logic [1:0] lane);
        return 4'b0001 << lane;
    endfunction

endpackage

// File: rtl/rf_wr_fifo.sv
// Two-entry posted-write FIFO for RF byte writes, with a combinational lookup
// that returns the newest queued data for a given RF address.
module rf_wr_fifo
    import ram_arb_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  rf_wr_entry_t push_entry,
    input  logic         pop,
    output rf_wr_entry_t head,
    output logic [1:0]   count,
    input  logic [7:0]   lookup_addr,
    output logic         hit,
    output logic [7:0]   hit_data
);

    rf_wr_entry_t mem_r [FIFO_DEPTH];
    logic         wr_ptr_r;
    logic         rd_ptr_r;
    logic [1:0]   count_r;
    logic         newest_s;

    // Storage, pointers and occupancy; the caller never pushes into a full FIFO without a pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r <= 1'b0;
            rd_ptr_r <= 1'b0;
            count_r  <= 2'd0;
        end else begin
            if (push) begin
                mem_r[wr_ptr_r] <= push_entry;
                wr_ptr_r        <= ~wr_ptr_r;
            end
            if (pop) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            case ({push, pop})
                2'b10:   count_r <= count_r + 2'd1;
                2'b01:   count_r <= count_r - 2'd1;
                default: count_r <= count_r;
            endcase
        end
    end

    assign newest_s = ~wr_ptr_r;
    assign head     = mem_r[rd_ptr_r];
    assign count    = count_r;

    // Forward lookup: the most recently pushed entry is checked first.
    always_comb begin
        hit      = 1'b0;
        hit_data = 8'h00;
        if ((count_r != 2'd0) && (mem_r[newest_s].addr == lookup_addr)) begin
            hit      = 1'b1;
            hit_data = mem_r[newest_s].data;
        end else if ((count_r == 2'd2) && (mem_r[rd_ptr_r].addr == lookup_addr)) begin
            hit      = 1'b1;
            hit_data = mem_r[rd_ptr_r].data;
        end else begin
            hit      = 1'b0;
            hit_data = 8'h00;
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one synchronous-read 32-bit RAM between the SERV RF byte port and the
// Wishbone data port: RF reads first, then posted RF-write drain, then Wishbone.
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int memsize = 1024,
    parameter int rf_base = 768,
    parameter int aw      = $clog2(memsize / 4)
) (
    input  logic          clk_top,
    input  logic          rst_n_top,
    input  logic [7:0]    i_raddr_top,
    input  logic          i_ren_top,
    input  logic [7:0]    i_waddr_top,
    input  logic [7:0]    i_wdata_top,
    input  logic          i_wen_top,
    output logic [7:0]    o_rdata_top,
    input  logic [9:2]    i_wb_adr_top,
    input  logic [31:0]   i_wb_dat_top,
    input  logic [3:0]    i_wb_sel_top,
    input  logic          i_wb_stb_top,
    input  logic          i_wb_we_top,
    output logic          o_wb_ack_top,
    output logic [31:0]   o_wb_rdt_top,
    output logic [aw-1:0] o_mem_addr,
    output logic          o_mem_we,
    output logic [3:0]    o_mem_be,
    output logic [31:0]   o_mem_wdata,
    input  logic [31:0]   i_mem_rdata,
    output logic          o_ovf_top
);

    function automatic logic [aw-1:0] rf_word(input logic [7:0] a);
        return aw'((32'(rf_base) + 32'(a)) >> 2);
    endfunction

    function automatic logic [1:0] rf_lane(input logic [7:0] a);
        return 2'(32'(rf_base) + 32'(a));
    endfunction

    wb_state_e    state_r;
    logic         ack_r;
    logic         ovf_r;
    logic         rd_pending_r;
    logic         rd_fwd_r;
    logic [7:0]   fwd_data_r;
    logic [1:0]   rd_lane_r;

    rf_wr_entry_t push_entry_s;
    rf_wr_entry_t head_s;
    logic [1:0]   count_s;
    logic         full_s;
    logic         pop_s;
    logic         push_s;
    logic         hit_s;
    logic [7:0]   hit_data_s;
    logic         grant_s;

    assign full_s       = (count_s == 2'(FIFO_DEPTH));
    assign pop_s        = !i_ren_top && (count_s != 2'd0);
    assign push_s       = i_wen_top && (!full_s || pop_s);
    assign push_entry_s = '{addr: i_waddr_top, data: i_wdata_top};
    assign grant_s      = (state_r == ST_IDLE) && i_wb_stb_top && !i_ren_top
                          && (count_s == 2'd0) && !i_wen_top;

    rf_wr_fifo u_fifo (
        .clk         (clk_top),
        .rst_n       (rst_n_top),
        .push        (push_s),
        .push_entry  (push_entry_s),
        .pop         (pop_s),
        .head        (head_s),
        .count       (count_s),
        .lookup_addr (i_raddr_top),
        .hit         (hit_s),
        .hit_data    (hit_data_s)
    );

    // Single RAM command per cycle; driven combinationally so read data lands one cycle later.
    always_comb begin
        o_mem_addr  = '0;
        o_mem_we    = 1'b0;
        o_mem_be    = 4'h0;
        o_mem_wdata = 32'h0;
        if (!rst_n_top) begin
            o_mem_addr  = '0;
            o_mem_we    = 1'b0;
        end else if (i_ren_top) begin
            o_mem_addr  = rf_word(i_raddr_top);
        end else if (pop_s) begin
            o_mem_addr  = rf_word(head_s.addr);
            o_mem_we    = 1'b1;
            o_mem_be    = lane_onehot(rf_lane(head_s.addr));
            o_mem_wdata = {4{head_s.data}};
        end else if (grant_s) begin
            o_mem_addr  = aw'(i_wb_adr_top);
            o_mem_we    = i_wb_we_top;
            o_mem_be    = i_wb_we_top ? i_wb_sel_top : 4'h0;
            o_mem_wdata = i_wb_dat_top;
        end else begin
            o_mem_addr  = '0;
            o_mem_we    = 1'b0;
        end
    end

    // Wishbone handshake FSM; stb is not sampled in ACK, so each grant yields one ack.
    always_ff @(posedge clk_top or negedge rst_n_top) begin
        if (!rst_n_top) begin
            state_r <= ST_IDLE;
            ack_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (grant_s) begin
                        state_r <= ST_ACK;
                        ack_r   <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                        ack_r   <= 1'b0;
                    end
                end
                ST_ACK: begin
                    state_r <= ST_IDLE;
                    ack_r   <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    ack_r   <= 1'b0;
                end
            endcase
        end
    end

    // RF read bookkeeping for the following cycle, plus the sticky overflow flag.
    always_ff @(posedge clk_top or negedge rst_n_top) begin
        if (!rst_n_top) begin
            rd_pending_r <= 1'b0;
            rd_fwd_r     <= 1'b0;
            fwd_data_r   <= 8'h00;
            rd_lane_r    <= 2'd0;
            ovf_r        <= 1'b0;
        end else begin
            rd_pending_r <= i_ren_top;
            rd_fwd_r     <= i_ren_top && hit_s;
            fwd_data_r   <= hit_data_s;
            rd_lane_r    <= rf_lane(i_raddr_top);
            ovf_r        <= ovf_r || (i_wen_top && full_s && !pop_s);
        end
    end

    // RF read data: forwarded byte or the addressed lane of the RAM word, zero otherwise.
    always_comb begin
        o_rdata_top = 8'h00;
        if (!rd_pending_r) begin
            o_rdata_top = 8'h00;
        end else if (rd_fwd_r) begin
            o_rdata_top = fwd_data_r;
        end else begin
            case (rd_lane_r)
                2'd0:    o_rdata_top = i_mem_rdata[7:0];
                2'd1:    o_rdata_top = i_mem_rdata[15:8];
                2'd2:    o_rdata_top = i_mem_rdata[23:16];
                2'd3:    o_rdata_top = i_mem_rdata[31:24];
                default: o_rdata_top = 8'h00;
            endcase
        end
    end

    assign o_wb_ack_top = ack_r;
    assign o_wb_rdt_top = ack_r ? i_mem_rdata : 32'h0;
    assign o_ovf_top    = ovf_r;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a behavioural synchronous-read RAM.
module tb_ram_port_arbiter;

    logic        clk;
    logic        rst_n;
    logic [7:0]  raddr;
    logic        ren;
    logic [7:0]  waddr;
    logic [7:0]  wdata;
    logic        wen;
    logic [7:0]  rdata;
    logic [9:2]  wb_adr;
    logic [31:0] wb_dat;
    logic [3:0]  wb_sel;
    logic        wb_stb;
    logic        wb_we;
    logic        wb_ack;
    logic [31:0] wb_rdt;
    logic [7:0]  mem_addr;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        ovf;

    logic        clr_ram;
    logic [31:0] ram [256];
    int          n_cmp;
    int          n_err;

    ram_port_arbiter dut (
        .clk_top      (clk),
        .rst_n_top    (rst_n),
        .i_raddr_top  (raddr),
        .i_ren_top    (ren),
        .i_waddr_top  (waddr),
        .i_wdata_top  (wdata),
        .i_wen_top    (wen),
        .o_rdata_top  (rdata),
        .i_wb_adr_top (wb_adr),
        .i_wb_dat_top (wb_dat),
        .i_wb_sel_top (wb_sel),
        .i_wb_stb_top (wb_stb),
        .i_wb_we_top  (wb_we),
        .o_wb_ack_top (wb_ack),
        .o_wb_rdt_top (wb_rdt),
        .o_mem_addr   (mem_addr),
        .o_mem_we     (mem_we),
        .o_mem_be     (mem_be),
        .o_mem_wdata  (mem_wdata),
        .i_mem_rdata  (mem_rdata),
        .o_ovf_top    (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) r[8*i +: 8] = nw[8*i +: 8];
        end
        return r;
    endfunction

    // Behavioural single-port RAM, read-first, one-cycle read latency.
    always @(posedge clk) begin
        if (clr_ram) begin
            for (int i = 0; i < 256; i++) ram[i] <= 32'h0;
            mem_rdata <= 32'h0;
        end else begin
            if (mem_we) ram[mem_addr] <= merge(ram[mem_addr], mem_wdata, mem_be);
            mem_rdata <= ram[mem_addr];
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        n_cmp = 0; n_err = 0;
        rst_n = 1'b0; clr_ram = 1'b1;
        raddr = 8'h00; ren = 1'b0; waddr = 8'h00; wdata = 8'h00; wen = 1'b0;
        wb_adr = 8'h00; wb_dat = 32'h0; wb_sel = 4'h0; wb_stb = 1'b0; wb_we = 1'b0;
        cyc(); cyc();
        clr_ram = 1'b0;
        chk("rst_rdata", 32'(rdata), 32'h0);
        chk("rst_ack", 32'(wb_ack), 32'h0);
        chk("rst_rdt", wb_rdt, 32'h0);
        chk("rst_ovf", 32'(ovf), 32'h0);
        chk("rst_we", 32'(mem_we), 32'h0);
        chk("rst_be", 32'(mem_be), 32'h0);
        chk("rst_addr", 32'(mem_addr), 32'h0);
        chk("rst_wdata", mem_wdata, 32'h0);
        rst_n = 1'b1;
        cyc();

        // RF write 0x0A<-0x5A, forwarded read next cycle, then drain and RAM read
        wen = 1'b1; waddr = 8'h0A; wdata = 8'h5A; cyc();
        wen = 1'b0; ren = 1'b1; raddr = 8'h0A; #1;
        chk("rd_addr", 32'(mem_addr), 32'd194);
        chk("rd_we", 32'(mem_we), 32'h0);
        cyc();
        ren = 1'b0; #1;
        chk("fwd_5a", 32'(rdata), 32'h5A);
        chk("drain_we", 32'(mem_we), 32'h1);
        chk("drain_addr", 32'(mem_addr), 32'd194);
        chk("drain_be", 32'(mem_be), 32'h4);
        chk("drain_wdata", mem_wdata, 32'h5A5A5A5A);
        cyc();
        chk("rdata_idle", 32'(rdata), 32'h0);
        cyc(); cyc();
        chk("ram194_a", ram[194], 32'h005A0000);
        ren = 1'b1; raddr = 8'h0A; wen = 1'b1; waddr = 8'h0A; wdata = 8'h77; cyc();
        ren = 1'b0; wen = 1'b0; #1;
        chk("ram_rd_no_same_cycle_fwd", 32'(rdata), 32'h5A);
        chk("drain_77", mem_wdata, 32'h77777777);
        cyc();
        chk("ram194_b", ram[194], 32'h00770000);

        // Wishbone write then read, then partial-select write
        wb_stb = 1'b1; wb_we = 1'b1; wb_adr = 8'h10; wb_dat = 32'hDEADBEEF; wb_sel = 4'hF; #1;
        chk("wb_wr_we", 32'(mem_we), 32'h1);
        chk("wb_wr_be", 32'(mem_be), 32'hF);
        chk("wb_wr_addr", 32'(mem_addr), 32'h10);
        chk("wb_ack_pre", 32'(wb_ack), 32'h0);
        cyc();
        chk("wb_ack_wr", 32'(wb_ack), 32'h1);
        #1;
        chk("wb_ack_cycle_no_access", 32'(mem_we), 32'h0);
        cyc();
        chk("wb_ack_one_cycle", 32'(wb_ack), 32'h0);
        wb_we = 1'b0; #1;
        chk("wb_rd_be", 32'(mem_be), 32'h0);
        chk("wb_rd_we", 32'(mem_we), 32'h0);
        cyc();
        chk("wb_ack_rd", 32'(wb_ack), 32'h1);
        chk("wb_rdt", wb_rdt, 32'hDEADBEEF);
        wb_stb = 1'b0; cyc();
        chk("wb_ack_low", 32'(wb_ack), 32'h0);
        chk("wb_rdt_low", wb_rdt, 32'h0);
        wb_stb = 1'b1; wb_we = 1'b1; wb_dat = 32'h0000CAFE; wb_sel = 4'h3; cyc();
        chk("wb_ack_wr2", 32'(wb_ack), 32'h1);
        cyc();
        wb_we = 1'b0; cyc();
        chk("wb_ack_rd2", 32'(wb_ack), 32'h1);
        chk("wb_rdt_sel3", wb_rdt, 32'hDEADCAFE);
        chk("wb_rdt_low_half", 32'(wb_rdt[15:0]), 32'hCAFE);
        wb_stb = 1'b0; cyc();

        // Wishbone held off by RF reads and queued writes
        wb_stb = 1'b1; wb_we = 1'b1; wb_adr = 8'h20; wb_dat = 32'h12345678; wb_sel = 4'hF;
        wen = 1'b1; waddr = 8'h00; wdata = 8'hA1; ren = 1'b0; cyc();
        chk("hold_h0", 32'(wb_ack), 32'h0);
        waddr = 8'h01; wdata = 8'hA2; ren = 1'b1; raddr = 8'h40; cyc();
        chk("hold_h1", 32'(wb_ack), 32'h0);
        wen = 1'b0; ren = 1'b0; #1;
        chk("hold_drain1_be", 32'(mem_be), 32'h1);
        chk("hold_drain1_addr", 32'(mem_addr), 32'd192);
        cyc();
        chk("hold_h2", 32'(wb_ack), 32'h0);
        ren = 1'b1; raddr = 8'h41; cyc();
        chk("hold_h3", 32'(wb_ack), 32'h0);
        ren = 1'b0; #1;
        chk("hold_drain2_be", 32'(mem_be), 32'h2);
        cyc();
        chk("hold_h4", 32'(wb_ack), 32'h0);
        ren = 1'b1; raddr = 8'h42; cyc();
        chk("hold_h5", 32'(wb_ack), 32'h0);
        ren = 1'b0; #1;
        chk("hold_grant_be", 32'(mem_be), 32'hF);
        chk("hold_grant_addr", 32'(mem_addr), 32'h20);
        cyc();
        chk("hold_ack", 32'(wb_ack), 32'h1);
        wb_stb = 1'b0; cyc();
        chk("hold_ack_once", 32'(wb_ack), 32'h0);
        chk("ram20", ram[32], 32'h12345678);
        chk("ram192", ram[192], 32'h0000A2A1);

        // FIFO overflow under continuous RF reads
        ren = 1'b1; raddr = 8'h80;
        wen = 1'b1; waddr = 8'h30; wdata = 8'hB1; cyc();
        waddr = 8'h31; wdata = 8'hB2; cyc();
        chk("ovf_before", 32'(ovf), 32'h0);
        waddr = 8'h32; wdata = 8'hB3; cyc();
        chk("ovf_set", 32'(ovf), 32'h1);
        ren = 1'b0; wen = 1'b0; #1;
        chk("ovf_drain1_addr", 32'(mem_addr), 32'd204);
        chk("ovf_drain1_be", 32'(mem_be), 32'h1);
        chk("ovf_drain1_wdata", mem_wdata, 32'hB1B1B1B1);
        cyc(); #1;
        chk("ovf_drain2_be", 32'(mem_be), 32'h2);
        chk("ovf_drain2_wdata", mem_wdata, 32'hB2B2B2B2);
        cyc(); #1;
        chk("ovf_no_third", 32'(mem_we), 32'h0);
        chk("ovf_sticky", 32'(ovf), 32'h1);
        cyc();
        chk("ram204", ram[204], 32'h0000B2B1);

        // Forwarding picks the newest of two matching entries
        ren = 1'b1; raddr = 8'h40; wen = 1'b1; waddr = 8'h05; wdata = 8'h11; cyc();
        raddr = 8'h41; wdata = 8'h22; cyc();
        wen = 1'b0; raddr = 8'h05; cyc();
        ren = 1'b0; #1;
        chk("fwd_newest", 32'(rdata), 32'h22);
        chk("fwd_drain_order1", mem_wdata, 32'h11111111);
        cyc(); #1;
        chk("fwd_drain_order2", mem_wdata, 32'h22222222);
        cyc();
        chk("ram193", ram[193], 32'h00002200);

        // Reset during the ACK cycle
        wb_stb = 1'b1; wb_we = 1'b0; wb_adr = 8'h10; wb_sel = 4'hF; cyc();
        chk("rst_ack_pre", 32'(wb_ack), 32'h1);
        #2; rst_n = 1'b0; #1;
        chk("rst_ack_async", 32'(wb_ack), 32'h0);
        chk("rst_rdt_async", wb_rdt, 32'h0);
        wb_stb = 1'b0; cyc();
        rst_n = 1'b1; cyc();
        chk("rst_ack_after", 32'(wb_ack), 32'h0);

        // Reset with two pending FIFO entries
        ren = 1'b1; raddr = 8'h40; wen = 1'b1; waddr = 8'h50; wdata = 8'hC1; cyc();
        waddr = 8'h51; wdata = 8'hC2; cyc();
        wen = 1'b0; #2; rst_n = 1'b0; #1;
        chk("rst2_we", 32'(mem_we), 32'h0);
        chk("rst2_addr", 32'(mem_addr), 32'h0);
        chk("rst2_be", 32'(mem_be), 32'h0);
        chk("rst2_wdata", mem_wdata, 32'h0);
        chk("rst2_rdata", 32'(rdata), 32'h0);
        chk("rst2_ovf", 32'(ovf), 32'h0);
        ren = 1'b0; cyc();
        rst_n = 1'b1; #1;
        chk("rst2_no_drain_a", 32'(mem_we), 32'h0);
        cyc(); #1;
        chk("rst2_no_drain_b", 32'(mem_we), 32'h0);
        cyc();
        chk("ram212", ram[212], 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
